// File: rtl/fp_add_pipe.sv
// IEEE-754 add/sub (RNE, subnormals, canonical NaN, flags, tag). 3-cycle latency, 1 op/cycle.
// Backpressure: one global advance (~out_valid | out_ready) freezes every stage; in_ready mirrors it.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_s,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int AW   = MAN_W + 3;
    localparam int SW   = MAN_W + 4;
    localparam int LZ_W = $clog2(SW + 1);
    localparam int CW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam logic [W-1:0]  CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [CW-1:0] EMAX      = CW'((1 << EXP_W) - 1);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;

    assign sa = in_a[W-1];
    assign ea = in_a[W-2:MAN_W];
    assign fa = in_a[MAN_W-1:0];
    assign sb = in_b[W-1] ^ in_sub;
    assign eb = in_b[W-2:MAN_W];
    assign fb = in_b[MAN_W-1:0];

    assign nan_a  = (&ea) & (|fa);
    assign nan_b  = (&eb) & (|fb);
    assign snan_a = nan_a & ~fa[MAN_W-1];
    assign snan_b = nan_b & ~fb[MAN_W-1];
    assign inf_a  = (&ea) & ~(|fa);
    assign inf_b  = (&eb) & ~(|fb);
    assign zero_a = ~(|ea) & ~(|fa);
    assign zero_b = ~(|eb) & ~(|fb);

    logic         spec_c, inv_c;
    logic [W-1:0] spec_res_c;

    always_comb begin
        spec_c     = 1'b1;
        inv_c      = 1'b0;
        spec_res_c = CANON_NAN;
        if (nan_a | nan_b)
            inv_c = snan_a | snan_b;
        else if (inf_a & inf_b & (sa ^ sb))
            inv_c = 1'b1;
        else if (inf_a)
            spec_res_c = {sa, ea, fa};
        else if (inf_b)
            spec_res_c = {sb, eb, fb};
        else if (zero_a & zero_b)
            spec_res_c = {sa & sb, {(W-1){1'b0}}};
        else if (zero_a)
            spec_res_c = {sb, eb, fb};
        else if (zero_b)
            spec_res_c = {sa, ea, fa};
        else
            spec_c = 1'b0;
    end

    // Raw {exp,frac} compares as magnitude, so the swap needs no decode.
    logic              swap, sign_l;
    logic [EXP_W-1:0]  exp_l, exp_s, diff;
    logic [MAN_W:0]    sig_l, sig_s;
    logic [31:0]       d32, sh32;
    logic [2*AW-1:0]   wide;
    logic [SW-1:0]     al_l, al_s;

    always_comb begin
        swap   = in_b[W-2:0] > in_a[W-2:0];
        sign_l = swap ? sb : sa;
        exp_l  = swap ? ((eb == '0) ? EXP_W'(1) : eb) : ((ea == '0) ? EXP_W'(1) : ea);
        exp_s  = swap ? ((ea == '0) ? EXP_W'(1) : ea) : ((eb == '0) ? EXP_W'(1) : eb);
        sig_l  = swap ? {|eb, fb} : {|ea, fa};
        sig_s  = swap ? {|ea, fa} : {|eb, fb};
        diff   = exp_l - exp_s;
        d32    = 32'(diff);
        sh32   = (d32 >= 32'(AW)) ? 32'(AW) : d32;
        wide   = {sig_s, 2'b00, {AW{1'b0}}} >> sh32;
        al_l   = {sig_l, 3'b000};
        al_s   = {wide[2*AW-1:AW], |wide[AW-1:0]};
    end

    logic             s1_vld, s1_spec, s1_inv, s1_sign, s1_sub;
    logic [W-1:0]     s1_spec_res;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_l, s1_s;
    logic [TAG_W-1:0] s1_tag;

    logic [SW:0] sum_c;
    assign sum_c = s1_sub ? ({1'b0, s1_l} - {1'b0, s1_s}) : ({1'b0, s1_l} + {1'b0, s1_s});

    logic             s2_vld, s2_spec, s2_inv, s2_sign;
    logic [W-1:0]     s2_spec_res;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;
    logic [TAG_W-1:0] s2_tag;

    function automatic logic [CW-1:0] lzc(input logic [SW-1:0] v);
        lzc = CW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) lzc = CW'(SW - 1 - i);
    endfunction

    logic [SW-1:0]    m;
    logic [CW-1:0]    lz, em1, nsh, ebase, eout;
    logic [MAN_W+1:0] rnd;
    logic             rup, inx, res_sign;
    logic [W-1:0]     res_c;
    logic [3:0]       flags_c;

    // Left normalisation stops at exponent 1; a hidden bit still 0 there means subnormal.
    always_comb begin
        lz       = lzc(s2_sum[SW-1:0]);
        em1      = CW'(s2_exp) - CW'(1);
        nsh      = '0;
        res_sign = (s2_sum == '0) ? 1'b0 : s2_sign;
        if (s2_sum[SW]) begin
            m     = {s2_sum[SW:2], |s2_sum[1:0]};
            ebase = CW'(s2_exp) + CW'(1);
        end else begin
            nsh   = (lz < em1) ? lz : em1;
            m     = s2_sum[SW-1:0] << nsh;
            ebase = m[SW-1] ? (CW'(s2_exp) - nsh) : '0;
        end
        rup     = m[2] & (m[1] | m[0] | m[3]);
        inx     = |m[2:0];
        rnd     = {1'b0, m[SW-1:3]} + (MAN_W+2)'(rup);
        eout    = ebase + CW'(rnd[MAN_W+1]) + CW'((ebase == '0) && rnd[MAN_W]);
        res_c   = {res_sign, eout[EXP_W-1:0], rnd[MAN_W-1:0]};
        flags_c = {1'b0, 1'b0, (eout == '0) & inx, inx};
        if (eout >= EMAX) begin
            res_c   = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_c = 4'b0101;
        end
        if (s2_spec) begin
            res_c   = s2_spec_res;
            flags_c = {s2_inv, 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            out_s     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            out_s     <= res_c;
            out_tag   <= s2_tag;
            out_flags <= flags_c;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_spec     <= spec_c;
            s1_inv      <= inv_c;
            s1_spec_res <= spec_res_c;
            s1_sign     <= sign_l;
            s1_sub      <= sa ^ sb;
            s1_exp      <= exp_l;
            s1_l        <= al_l;
            s1_s        <= al_s;
            s1_tag      <= in_tag;
            s2_spec     <= s1_spec;
            s2_inv      <= s1_inv;
            s2_spec_res <= s1_spec_res;
            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_c;
            s2_tag      <= s1_tag;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe (binary32): directed vectors, stall and reset flush.
module tb_fp_add_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] out_s;
    logic [4:0]  out_tag;
    logic [3:0]  out_flags;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_tag(out_tag), .out_flags(out_flags)
    );

    typedef struct {
        logic [31:0] s;
        logic [4:0]  tag;
        logic [3:0]  flags;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    int          acc_cnt = 0;
    logic [40:0] held;
    bit          held_vld = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && held_vld) begin
                checks++;
                if ({out_s, out_tag, out_flags} !== held) begin
                    errors++;
                    $display("FAIL hold got %0h want %0h", {out_s, out_tag, out_flags}, held);
                end
            end
            held_vld = out_valid && !out_ready;
            held     = {out_s, out_tag, out_flags};
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_stall got %b want 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got %h want none", out_s);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", 64'(out_s), 64'(mon_e.s));
                    chk("tag", 64'(out_tag), 64'(mon_e.tag));
                    chk("flags", 64'(out_flags), 64'(mon_e.flags));
                    if (mon_e.chk_lat) chk("latency", 64'(cyc - mon_e.acc), 64'd3);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [4:0] tag, input logic [31:0] es, input logic [3:0] ef,
                         input bit lat);
        exp_t e;
        int   n;
        in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout got in_ready %b want 1", in_ready);
        end else begin
            e.s = es; e.tag = tag; e.flags = ef; e.acc = cyc; e.chk_lat = lat;
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int base_cnt;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_s", 64'(out_s), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // flags = {invalid, overflow, underflow, inexact}
        issue(32'h3F800000, 32'h40000000, 1'b0, 5'd3,  32'h40400000, 4'b0000, 1'b1);
        issue(32'h3F800000, 32'h3F800000, 1'b1, 5'd4,  32'h00000000, 4'b0000, 1'b1);
        issue(32'h80000000, 32'h80000000, 1'b0, 5'd5,  32'h80000000, 4'b0000, 1'b1);
        issue(32'h3F800000, 32'h33800000, 1'b0, 5'd6,  32'h3F800000, 4'b0001, 1'b1);
        issue(32'h3F800001, 32'h33800000, 1'b0, 5'd7,  32'h3F800002, 4'b0001, 1'b1);
        issue(32'h7F800000, 32'hFF800000, 1'b0, 5'd8,  32'h7FC00000, 4'b1000, 1'b1);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd9,  32'h7F800000, 4'b0101, 1'b1);
        issue(32'h7F800001, 32'h3F800000, 1'b0, 5'd10, 32'h7FC00000, 4'b1000, 1'b1);
        issue(32'h00000001, 32'h00000001, 1'b0, 5'd11, 32'h00000002, 4'b0000, 1'b1);
        issue(32'h00800000, 32'h00000001, 1'b1, 5'd12, 32'h007FFFFF, 4'b0000, 1'b1);
        issue(32'h3F800000, 32'h40000000, 1'b1, 5'd13, 32'hBF800000, 4'b0000, 1'b1);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 5'd14, 32'h7FC00000, 4'b0000, 1'b1);
        issue(32'h7F800000, 32'h3F800000, 1'b1, 5'd15, 32'h7F800000, 4'b0000, 1'b1);
        issue(32'h00000000, 32'h3F800000, 1'b1, 5'd16, 32'hBF800000, 4'b0000, 1'b1);
        drain();

        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd20, 32'h40000000, 4'b0000, 1'b0);
        issue(32'h40000000, 32'h40000000, 1'b0, 5'd21, 32'h40800000, 4'b0000, 1'b0);
        issue(32'h3F800000, 32'h40000000, 1'b0, 5'd22, 32'h40400000, 4'b0000, 1'b0);
        issue(32'h40400000, 32'h3F800000, 1'b0, 5'd23, 32'h40800000, 4'b0000, 1'b0);
        issue(32'h40800000, 32'h3F800000, 1'b1, 5'd24, 32'h40400000, 4'b0000, 1'b0);
        drain();

        issue(32'h3F800000, 32'h3F800000, 1'b0, 5'd30, 32'h40000000, 4'b0000, 1'b0);
        issue(32'h40000000, 32'h3F800000, 1'b0, 5'd31, 32'h40400000, 4'b0000, 1'b0);
        rst = 1'b1;
        sb.delete();
        base_cnt = out_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (8) @(negedge clk);
        chk("flush_no_stale", 64'(out_cnt - base_cnt), 64'd0);
        drain();
        chk("total_outputs", 64'(out_cnt), 64'(acc_cnt - 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
